// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product feeder and its downstream
// element-stream accumulator.
package dot_product_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_WAIT_RES
    } state_t;

    function automatic int res_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    localparam int RES_W = res_width(DEF_WIDTH, DEF_N);

endpackage

// File: rtl/dot_product_feeder_if.sv
// Vector-in / element-out bundle between an upstream source, the feeder
// and the downstream dot-product unit.
interface dot_product_feeder_if
    import dot_product_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
);
    logic               vec_valid;
    logic               vec_ready;
    logic [WIDTH*N-1:0] a_flat;
    logic [WIDTH*N-1:0] b_flat;
    logic               result_valid;
    logic               input_valid;
    logic [WIDTH-1:0]   A_vec;
    logic [WIDTH-1:0]   B_vec;
    logic               busy;
    logic               timeout_err;

    modport master (
        output vec_valid, a_flat, b_flat, result_valid,
        input  vec_ready, input_valid, A_vec, B_vec, busy, timeout_err
    );

    modport slave (
        input  vec_valid, a_flat, b_flat, result_valid,
        output vec_ready, input_valid, A_vec, B_vec, busy, timeout_err
    );
endinterface

// File: rtl/dot_product_stream.sv
// Downstream consumer: accumulates N element products and pulses
// output_valid with the finished dot product.
module dot_product_stream
    import dot_product_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    localparam int RW   = res_width(WIDTH, N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_valid,
    input  logic [WIDTH-1:0] A_vec,
    input  logic [WIDTH-1:0] B_vec,
    output logic             output_valid,
    output logic [RW-1:0]    result
);
    localparam int IW = $clog2(N);

    logic [RW-1:0] acc;
    logic [RW-1:0] sum;
    logic [IW-1:0] cnt;

    assign sum = acc + RW'(A_vec) * RW'(B_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            if (input_valid) begin
                if (cnt == IW'(N - 1)) begin
                    result       <= sum;
                    output_valid <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + IW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/vec_fifo2.sv
// Two-entry vector FIFO; ready is registered so it never depends on a
// same-cycle pop.
module vec_fifo2 #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          ready
);
    logic [DW-1:0] mem [2];
    logic          wp;
    logic          rp;
    logic [1:0]    cnt;
    logic [1:0]    cnt_n;

    always_comb begin
        cnt_n = cnt + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= 2'd0;
            ready <= 1'b0;
        end else begin
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            cnt   <= cnt_n;
            ready <= (cnt_n != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign empty = (cnt == 2'd0);
endmodule

// File: rtl/dot_product_feeder.sv
// Buffers whole A/B vectors and serialises them element by element into a
// streaming dot-product unit, with optional result handshake and timeout.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N           = DEF_N,
    parameter int GAP         = 1,
    parameter int WAIT_RESULT = 0,
    parameter int TIMEOUT     = N + 8
) (
    input logic clk,
    input logic rst_n,
    dot_product_feeder_if.slave bus
);
    localparam int VW = WIDTH * N;
    localparam int DW = 2 * VW;
    localparam int IW = $clog2(N);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state, state_n;
    logic [IW-1:0]  idx, idx_n;
    logic [GW-1:0]  gap_cnt, gap_n;
    logic [TW-1:0]  to_cnt, to_n;
    logic           early, early_n;
    logic           terr, terr_n;
    logic [DW-1:0]  cur, cur_n;
    logic           iv, iv_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic           start;
    logic           pop;
    logic           push;
    logic           empty;
    logic           fifo_ready;
    logic [DW-1:0]  head;

    assign push = bus.vec_valid && fifo_ready;

    vec_fifo2 #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({bus.b_flat, bus.a_flat}),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .ready (fifo_ready)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        gap_n   = gap_cnt;
        to_n    = to_cnt;
        early_n = early;
        terr_n  = terr;
        cur_n   = cur;
        iv_n    = 1'b0;
        a_n     = '0;
        b_n     = '0;
        start   = 1'b0;
        pop     = 1'b0;

        // a result that beats WAIT_RES is remembered so the wait is skipped
        if (bus.result_valid && (state == S_STREAM || state == S_GAP))
            early_n = 1'b1;

        unique case (state)
            S_IDLE: begin
                start = !empty;
            end
            S_STREAM: begin
                if (idx == IW'(N - 1)) begin
                    state_n = S_GAP;
                    gap_n   = '0;
                end else begin
                    idx_n = idx + IW'(1);
                    iv_n  = 1'b1;
                    a_n   = cur[int'(idx_n) * WIDTH +: WIDTH];
                    b_n   = cur[VW + int'(idx_n) * WIDTH +: WIDTH];
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    if (WAIT_RESULT != 0) begin
                        state_n = S_WAIT_RES;
                        to_n    = '0;
                    end else begin
                        state_n = S_IDLE;
                        start   = !empty;
                    end
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            S_WAIT_RES: begin
                if (bus.result_valid || early) begin
                    early_n = 1'b0;
                    state_n = S_IDLE;
                    start   = !empty;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    early_n = 1'b0;
                    terr_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    to_n = to_cnt + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // element 0 comes straight from the FIFO head so no cycle is lost
        if (start) begin
            pop     = 1'b1;
            cur_n   = head;
            state_n = S_STREAM;
            idx_n   = '0;
            iv_n    = 1'b1;
            a_n     = head[0 +: WIDTH];
            b_n     = head[VW +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            to_cnt  <= '0;
            early   <= 1'b0;
            terr    <= 1'b0;
            cur     <= '0;
            iv      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gap_cnt <= gap_n;
            to_cnt  <= to_n;
            early   <= early_n;
            terr    <= terr_n;
            cur     <= cur_n;
            iv      <= iv_n;
            a_q     <= a_n;
            b_q     <= b_n;
        end
    end

    assign bus.vec_ready   = fifo_ready;
    assign bus.input_valid = iv;
    assign bus.A_vec       = a_q;
    assign bus.B_vec       = b_q;
    assign bus.busy        = (state != S_IDLE) || !empty;
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_dot_product_feeder.sv
// End-to-end bench: feeder driving the streaming dot-product unit, checked
// against a vector-level model of expected elements and results.
module tb_dot_product_feeder;
    import dot_product_pkg::*;

    localparam int W   = 8;
    localparam int NN  = 4;
    localparam int GP  = 1;
    localparam int TO  = NN + 8;
    localparam int RW  = res_width(W, NN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rv_en = 1'b1;
    always #5 clk = ~clk;

    dot_product_feeder_if #(.WIDTH(W), .N(NN)) if0 ();
    dot_product_feeder_if #(.WIDTH(W), .N(NN)) if1 ();

    logic          ov0, ov1;
    logic [RW-1:0] res0, res1;

    dot_product_feeder #(.WIDTH(W), .N(NN), .GAP(GP), .WAIT_RESULT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    dot_product_feeder #(.WIDTH(W), .N(NN), .GAP(GP), .WAIT_RESULT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    dot_product_stream #(.WIDTH(W), .N(NN)) ds0 (
        .clk(clk), .rst_n(rst_n), .input_valid(if0.input_valid),
        .A_vec(if0.A_vec), .B_vec(if0.B_vec),
        .output_valid(ov0), .result(res0)
    );
    dot_product_stream #(.WIDTH(W), .N(NN)) ds1 (
        .clk(clk), .rst_n(rst_n), .input_valid(if1.input_valid),
        .A_vec(if1.A_vec), .B_vec(if1.B_vec),
        .output_valid(ov1), .result(res1)
    );

    assign if0.result_valid = ov0;
    assign if1.result_valid = ov1 & rv_en;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int zviol = 0;

    logic [15:0] e0_q[$], e1_q[$], x0_e[$], x1_e[$];
    int          r0_q[$], r1_q[$], x0_r[$], x1_r[$];
    int          iv0_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if0.input_valid) begin
            e0_q.push_back({if0.A_vec, if0.B_vec});
            iv0_q.push_back(cyc);
        end else if (if0.A_vec != '0 || if0.B_vec != '0) begin
            zviol <= zviol + 1;
        end
        if (if1.input_valid) e1_q.push_back({if1.A_vec, if1.B_vec});
        else if (if1.A_vec != '0 || if1.B_vec != '0) zviol <= zviol + 1;
        if (ov0) r0_q.push_back(int'(res0));
        if (ov1) r1_q.push_back(int'(res1));
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // vector-level model: element order and the arithmetic dot product
    task automatic model(input int inst, input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea [NN];
        logic [7:0] eb [NN];
        int s;
        s = 0;
        for (int i = 0; i < NN; i++) begin
            ea[i] = a[i*8 +: 8];
            eb[i] = b[i*8 +: 8];
            s += int'(ea[i]) * int'(eb[i]);
            if (inst == 0) x0_e.push_back({ea[i], eb[i]});
            else x1_e.push_back({ea[i], eb[i]});
        end
        if (inst == 0) x0_r.push_back(s);
        else x1_r.push_back(s);
    endtask

    task automatic push(input int inst, input logic [31:0] a,
                        input logic [31:0] b, output int waits);
        bit ok;
        logic rdy;
        ok = 0;
        waits = 0;
        if (inst == 0) begin
            if0.vec_valid = 1'b1; if0.a_flat = a; if0.b_flat = b;
        end else begin
            if1.vec_valid = 1'b1; if1.a_flat = a; if1.b_flat = b;
        end
        for (int t = 0; t < 300; t++) begin
            rdy = (inst == 0) ? if0.vec_ready : if1.vec_ready;
            if (rdy) begin
                ok = 1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (ok) begin
            model(inst, a, b);
            @(negedge clk);
        end else begin
            chk("push_accept_timeout", 0, 1);
        end
        if (inst == 0) if0.vec_valid = 1'b0;
        else if1.vec_valid = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        logic bz;
        bz = 1'b1;
        for (int t = 0; t < 500 && bz; t++) begin
            @(negedge clk);
            bz = (inst == 0) ? if0.busy : if1.busy;
        end
        chk("idle_reached", bz, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare(input int inst, input string tag);
        int          or_q[$], xr_q[$];
        logic [15:0] oe_q[$], xe_q[$];
        if (inst == 0) begin
            or_q = r0_q; xr_q = x0_r; oe_q = e0_q; xe_q = x0_e;
        end else begin
            or_q = r1_q; xr_q = x1_r; oe_q = e1_q; xe_q = x1_e;
        end
        chk({tag, "_nres"}, or_q.size(), xr_q.size());
        for (int i = 0; i < or_q.size() && i < xr_q.size(); i++)
            chk({tag, "_res"}, or_q[i], xr_q[i]);
        chk({tag, "_nelem"}, oe_q.size(), xe_q.size());
        for (int i = 0; i < oe_q.size() && i < xe_q.size(); i++)
            chk({tag, "_elem"}, oe_q[i], xe_q[i]);
        if (inst == 0) begin
            r0_q.delete(); x0_r.delete(); e0_q.delete(); x0_e.delete();
            iv0_q.delete();
        end else begin
            r1_q.delete(); x1_r.delete(); e1_q.delete(); x1_e.delete();
        end
    endtask

    task automatic flush_all();
        r0_q.delete(); x0_r.delete(); e0_q.delete(); x0_e.delete();
        r1_q.delete(); x1_r.delete(); e1_q.delete(); x1_e.delete();
        iv0_q.delete();
    endtask

    initial begin
        int w;
        int wv [5];
        int k;
        bit seen;

        if0.vec_valid = 1'b0; if0.a_flat = '0; if0.b_flat = '0;
        if1.vec_valid = 1'b0; if1.a_flat = '0; if1.b_flat = '0;
        repeat (2) @(negedge clk);

        chk("rst_iv", if0.input_valid, 0);
        chk("rst_a", if0.A_vec, 0);
        chk("rst_b", if0.B_vec, 0);
        chk("rst_ready", if0.vec_ready, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_terr", if0.timeout_err, 0);
        chk("rst_terr1", if1.timeout_err, 0);

        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", if0.vec_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", if0.vec_ready, 1);

        // all-ones vector
        push(0, 32'h01010101, 32'h01010101, w);
        wait_idle(0);
        chk("ones_niv", iv0_q.size(), 4);
        if (iv0_q.size() == 4) chk("ones_consec", iv0_q[3] - iv0_q[0], 3);
        if (r0_q.size() > 0) chk("ones_result", r0_q[0], 4);
        compare(0, "ones");

        // back-to-back bursts, one idle cycle between them
        push(0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd2, 8'd0, 8'd1, 8'd10}, w);
        push(0, 32'hffffffff, 32'h01010101, w);
        wait_idle(0);
        chk("b2b_niv", iv0_q.size(), 8);
        if (iv0_q.size() == 8) begin
            chk("b2b_burst0", iv0_q[3] - iv0_q[0], 3);
            chk("b2b_gap", iv0_q[4] - iv0_q[3], 2);
            chk("b2b_burst1", iv0_q[7] - iv0_q[4], 3);
        end
        if (r0_q.size() == 2) begin
            chk("b2b_res0", r0_q[0], 20);
            chk("b2b_res1", r0_q[1], 1020);
        end
        compare(0, "b2b");

        // FIFO fill: valid held while full, ready must drop
        for (int i = 0; i < 5; i++) push(0, $urandom, $urandom, wv[i]);
        chk("fill_nowait", wv[0] + wv[1] + wv[2], 0);
        chk("fill_backpressure", wv[3] > 0, 1);
        wait_idle(0);
        chk("fill_niv", iv0_q.size(), 20);
        if (iv0_q.size() == 20)
            for (int i = 1; i < 5; i++)
                chk("fill_period", iv0_q[4*i] - iv0_q[4*(i-1)], NN + GP);
        compare(0, "fill");

        // random traffic with random spacing
        for (int i = 0; i < 10; i++) begin
            push(0, $urandom, $urandom, w);
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        wait_idle(0);
        compare(0, "rand");

        // wait-for-result mode, result arrives early during GAP
        push(1, $urandom, $urandom, w);
        push(1, $urandom, $urandom, w);
        wait_idle(1);
        chk("wait_terr_clear", if1.timeout_err, 0);
        compare(1, "wait");

        // result suppressed -> timeout after GAP+TIMEOUT cycles
        rv_en = 1'b0;
        push(1, $urandom, $urandom, w);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (if1.input_valid) seen = 1;
            else @(negedge clk);
        end
        chk("to_stream_seen", seen, 1);
        for (int t = 0; t < 50 && if1.input_valid; t++) @(negedge clk);
        k = 0;
        for (int t = 0; t < 100 && !if1.timeout_err; t++) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", k, GP + TO);
        chk("to_terr", if1.timeout_err, 1);
        chk("to_idle", if1.busy, 0);
        rv_en = 1'b1;
        push(1, $urandom, $urandom, w);
        wait_idle(1);
        chk("to_sticky", if1.timeout_err, 1);
        compare(1, "after_to");

        // reset while element 2 is on the bus, second vector queued
        push(0, $urandom, $urandom, w);
        push(0, $urandom, $urandom, w);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (if0.input_valid) seen = 1;
            else @(negedge clk);
        end
        chk("rst_mid_seen", seen, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_iv", if0.input_valid, 0);
        chk("rst_mid_a", if0.A_vec, 0);
        chk("rst_mid_busy", if0.busy, 0);
        chk("rst_mid_ready", if0.vec_ready, 0);
        flush_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_reready", if0.vec_ready, 1);
        push(0, {8'd11, 8'd22, 8'd33, 8'd55}, 32'h0, w);
        wait_idle(0);
        chk("rst_fresh_nres", r0_q.size(), 1);
        if (r0_q.size() == 1) chk("rst_fresh_res", r0_q[0], 0);
        compare(0, "rst_fresh");

        chk("zero_when_idle", zviol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
